// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    // Fetch sequencer states, one instruction in flight at a time.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PC_DRIVE   = 3'd1,
        ADDR_LATCH = 3'd2,
        MEM_WAIT   = 3'd3,
        HOLD       = 3'd4,
        INC        = 3'd5
    } fetch_state_t;

    localparam int FETCH_ADDR_W         = 16;
    localparam int FETCH_DATA_W         = 16;
    localparam int FETCH_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/fetch_watchdog.sv
// Memory-wait watchdog: counts MEM_WAIT cycles without ack, flags expiry.
// Latency: expired is combinational in the limit cycle (count registered).
// Backpressure: none; a same-cycle ack always suppresses expiry.
//
// Ports: clock/reset, start (cycle before MEM_WAIT, clears count),
//        waiting (in MEM_WAIT), ack (memory ack), expired (limit hit, no ack).
module fetch_watchdog
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = FETCH_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic waiting,
    input  logic ack,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The count holds the number of already-finished ack-less cycles, so the
    // limit is reached in the cycle where it equals TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (waiting && !ack) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = waiting && !ack && (cnt == LIMIT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC strobe -> MAR latch -> req/ack read -> hold for decoder.
// Latency: 5 cycles per instruction minimum; instr_valid 4 cycles after run seen in IDLE.
// Backpressure: holds the word (instr_valid) until instr_ready; waits on mem_ack indefinitely
//               unless FETCH_TIMEOUT_EN is defined, which adds a MEM_WAIT timeout and sticky fault.
//
// Ports: clock, reset (async active-low), run (level), pc_enable_out / pc_enable_increment
//        (PC strobes), addr_bus (PC bus, sampled in ADDR_LATCH only), mem_addr/mem_req/
//        mem_ack/mem_rdata (program memory), instr/instr_valid/instr_ready (decoder),
//        busy (not IDLE), fault (sticky timeout, 0 without FETCH_TIMEOUT_EN).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W         = FETCH_ADDR_W,
    parameter int DATA_W         = FETCH_DATA_W,
    parameter int TIMEOUT_CYCLES = FETCH_TIMEOUT_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic              pc_enable_out,
    output logic              pc_enable_increment,
    input  logic [ADDR_W-1:0] addr_bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              fault
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         timeout;
    logic         fault_q;

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .start   (state == ADDR_LATCH),
        .waiting (state == MEM_WAIT),
        .ack     (mem_ack),
        .expired (timeout)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (timeout) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    // Constant 0 for any legal limit; the watchdog is not built here.
    assign fault_q = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Moore-decoded strobes. Because every output is a pure
    // function of state, an asynchronous reset clears them immediately.
    always_comb begin
        state_nxt           = state;
        pc_enable_out       = 1'b0;
        pc_enable_increment = 1'b0;
        mem_req             = 1'b0;
        instr_valid         = 1'b0;
        case (state)
            IDLE: begin
                // A latched fault parks the unit until reset.
                if (run && !fault_q) begin
                    state_nxt = PC_DRIVE;
                end
            end
            PC_DRIVE: begin
                pc_enable_out = 1'b1;
                state_nxt     = ADDR_LATCH;
            end
            ADDR_LATCH: begin
                pc_enable_out = 1'b1;
                state_nxt     = MEM_WAIT;
            end
            MEM_WAIT: begin
                mem_req = 1'b1;
                // Ack takes priority over a timeout in the same cycle.
                if (mem_ack) begin
                    state_nxt = HOLD;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    state_nxt = INC;
                end
            end
            INC: begin
                pc_enable_increment = 1'b1;
                state_nxt           = run ? PC_DRIVE : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory address register: the bus is only meaningful while the PC drives
    // it, which is the ADDR_LATCH cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_addr <= '0;
        end else if (state == ADDR_LATCH) begin
            mem_addr <= addr_bus;
        end
    end

    // Instruction register: written only on the accepting ack, so it stays
    // stable for the whole HOLD phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr <= '0;
        end else if ((state == MEM_WAIT) && mem_ack) begin
            instr <= mem_rdata;
        end
    end

    assign busy  = (state != IDLE);
    assign fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetches, a monitor checks them.
// Latency: n/a.
// Backpressure: memory ack and decoder ready delays are programmable per test.
module tb_fetch_unit;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 4;
`ifdef FETCH_TIMEOUT_EN
    // With the watchdog at 4, the slow-ack case lands exactly on the limit.
    localparam int ACK_SLOW = 4;
`else
    localparam int ACK_SLOW = 8;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          run   = 1'b0;
    logic          pc_enable_out;
    logic          pc_enable_increment;
    logic [AW-1:0] addr_bus;
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          busy;
    logic          fault;

    fetch_unit #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .run                 (run),
        .pc_enable_out       (pc_enable_out),
        .pc_enable_increment (pc_enable_increment),
        .addr_bus            (addr_bus),
        .mem_addr            (mem_addr),
        .mem_req             (mem_req),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .instr               (instr),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .busy                (busy),
        .fault               (fault)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- PC model ----------------
    // Loads pc_init while reset is low, drives the bus the edge after
    // pc_enable_out, advances on the increment strobe.
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_init = '0;
    logic          pc_drv;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc     <= pc_init;
            pc_drv <= 1'b0;
        end else begin
            pc_drv <= pc_enable_out;
            if (pc_enable_increment) pc <= pc + 16'd1;
        end
    end

    // Undriven bus shows a marker instead of high-Z.
    assign addr_bus = pc_drv ? pc : 16'hDEAD;

    // ---------------- memory and decoder models ----------------
    int   ack_wait   = 1;
    int   ready_wait = 1;
    int   req_cnt    = 0;
    int   rdy_cnt    = 0;
    logic stray_ack  = 1'b0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 16'h0000) return 16'hA5A5;
        return {a[7:0], ~a[7:0]};
    endfunction

    always @(negedge clock) begin
        if (mem_req) begin
            req_cnt = req_cnt + 1;
            mem_ack = stray_ack || (req_cnt == ack_wait);
        end else begin
            req_cnt = 0;
            mem_ack = stray_ack;
        end
        mem_rdata = mem_word(mem_addr);
        if (instr_valid) begin
            rdy_cnt     = rdy_cnt + 1;
            instr_ready = (rdy_cnt == ready_wait);
        end else begin
            rdy_cnt     = 0;
            instr_ready = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            req_len;   // cycles mem_req is high
        int            hold_len;  // cycles instr_valid is high
        int            inc_gap;   // cycles since previous increment, 0 = unchecked
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   have     = 1'b0;
    bit   unstable = 1'b0;
    logic prev_pe  = 1'b0;
    logic prev_req = 1'b0;
    logic prev_val = 1'b0;
    int   t_start  = 0;
    int   t_req    = 0;
    int   t_val    = 0;
    int   last_inc = 0;

    always @(negedge clock) begin
        if (!reset) begin
            have     = 1'b0;
            prev_pe  = 1'b0;
            prev_req = 1'b0;
            prev_val = 1'b0;
            last_inc = 0;
        end else begin
            if (pc_enable_out && !prev_pe) begin
                if (exp_q.size() == 0) begin
                    check("fetch_start_unexpected", 32'd1, 32'd0);
                end else begin
                    cur     = exp_q.pop_front();
                    have    = 1'b1;
                    t_start = cyc;
                end
            end
            if (mem_req && !prev_req) begin
                t_req = cyc;
                check("mem_addr", 32'(mem_addr), 32'(cur.addr));
            end
            if (!mem_req && prev_req) begin
                check("req_cycles", 32'(cyc - t_req), 32'(cur.req_len));
            end
            if (instr_valid && !prev_val) begin
                t_val    = cyc;
                unstable = 1'b0;
                check("valid_latency", 32'(cyc - t_start), 32'(2 + cur.req_len));
                check("instr", 32'(instr), 32'(cur.data));
            end else if (instr_valid && (instr !== cur.data)) begin
                unstable = 1'b1;
            end
            if (!instr_valid && prev_val) begin
                check("hold_cycles", 32'(cyc - t_val), 32'(cur.hold_len));
                check("instr_stable", 32'(unstable), 32'd0);
            end
            if (pc_enable_increment) begin
                if (!have) begin
                    check("inc_unexpected", 32'd1, 32'd0);
                end else begin
                    check("inc_cycle", 32'(cyc - t_val), 32'(cur.hold_len));
                    if (cur.inc_gap != 0) check("inc_gap", 32'(cyc - last_inc), 32'(cur.inc_gap));
                    have = 1'b0;
                end
                last_inc = cyc;
            end
            prev_pe  = pc_enable_out;
            prev_req = mem_req;
            prev_val = instr_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset(input logic [AW-1:0] pc0, input logic run_at_release);
        reset   = 1'b0;
        run     = 1'b0;
        pc_init = pc0;
        repeat (2) @(posedge clock);
        exp_q.delete();
        #2;
        run   = run_at_release;
        reset = 1'b1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int rl, input int hl, input int gap);
        exp_t e;
        e.addr = a; e.data = d; e.req_len = rl; e.hold_len = hl; e.inc_gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic end_of_test(input string tag);
        #1;
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_pc_enable_out", 32'(pc_enable_out), 32'd0);
        check("rst_pc_enable_increment", 32'(pc_enable_increment), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        // Test 1: first fetch after reset release with run high, PC at 0.
        do_reset(16'h0000, 1'b1);
        push(16'h0000, 16'hA5A5, 1, 1, 0);
        @(posedge clock);
        @(posedge clock);
        #2 run = 1'b0;
        repeat (10) @(posedge clock);
        end_of_test("t1");

        // Test 2: three back-to-back fetches from 0x0010.
        do_reset(16'h0010, 1'b1);
        push(16'h0010, 16'h10EF, 1, 1, 0);
        push(16'h0011, 16'h11EE, 1, 1, 5);
        push(16'h0012, 16'h12ED, 1, 1, 5);
        repeat (12) @(posedge clock);
        #2 run = 1'b0;
        repeat (12) @(posedge clock);
        end_of_test("t2");

        // Test 3: slow ack and slow ready.
        ack_wait   = ACK_SLOW;
        ready_wait = 4;
        do_reset(16'h0020, 1'b1);
        push(16'h0020, 16'h20DF, ACK_SLOW, 4, 0);
        @(posedge clock);
        @(posedge clock);
        #2 run = 1'b0;
        repeat (25) @(posedge clock);
        end_of_test("t3");
        ack_wait   = 1;
        ready_wait = 1;

        // Test 4: reset in the middle of MEM_WAIT, then a stray ack.
        ack_wait = 100;
        do_reset(16'h0030, 1'b1);
        push(16'h0030, 16'h30CF, 100, 1, 0);
        repeat (5) @(posedge clock);
        #2;
        check("t4_req_before_reset", 32'(mem_req), 32'd1);
        reset = 1'b0;
        run   = 1'b0;
        #1;
        check("t4_req_async", 32'(mem_req), 32'd0);
        check("t4_busy_async", 32'(busy), 32'd0);
        check("t4_pc_enable_out_async", 32'(pc_enable_out), 32'd0);
        check("t4_mem_addr_async", 32'(mem_addr), 32'd0);
        @(posedge clock);
        #2;
        exp_q.delete();
        ack_wait  = 1;
        reset     = 1'b1;
        stray_ack = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("t4_stray_busy", 32'(busy), 32'd0);
        check("t4_stray_instr", 32'(instr), 32'd0);
        check("t4_stray_valid", 32'(instr_valid), 32'd0);
        stray_ack = 1'b0;

        // Test 5: PC wrap is the PC's job; the unit just latches the bus.
        do_reset(16'hFFFF, 1'b1);
        push(16'hFFFF, 16'hFF00, 1, 1, 0);
        push(16'h0000, 16'hA5A5, 1, 1, 5);
        repeat (7) @(posedge clock);
        #2 run = 1'b0;
        repeat (15) @(posedge clock);
        end_of_test("t5");

`ifdef FETCH_TIMEOUT_EN
        // Test 6: memory never acks; watchdog fires after 4 MEM_WAIT cycles.
        ack_wait = 1000;
        do_reset(16'h0040, 1'b1);
        push(16'h0040, 16'h40BF, TO, 1, 0);
        repeat (20) @(posedge clock);
        #1;
        check("t6_fault", 32'(fault), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_mem_req", 32'(mem_req), 32'd0);
        reset = 1'b0;
        #1;
        check("t6_fault_cleared", 32'(fault), 32'd0);
        ack_wait = 1;
        @(posedge clock);
        #2 reset = 1'b1;
`else
        // Without the watchdog the fault flag never rises.
        #1;
        check("fault_tied_low", 32'(fault), 32'd0);
`endif

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
